chunk_addsub: RTL and testbench
===============================

CHUNK_ADDSUB -- requirements
Module: chunk_addsub

Interface
REQ-001 The module SHALL have parameter NUM_SIZE, default 32, operand/result width in bits.
REQ-002 The module SHALL have parameter CHUNK_SIZE, default 8, bits added per cycle; NUM_SIZE SHALL be an integer multiple of CHUNK_SIZE.
REQ-003 The module SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 The module SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port dIn0, input, NUM_SIZE, augend/minuend.
REQ-006 The module SHALL have port dIn1, input, NUM_SIZE, addend/subtrahend.
REQ-007 The module SHALL have port sub, input, 1, 1 = dIn0 - dIn1, 0 = dIn0 + dIn1.
REQ-008 The module SHALL have ports inValid (input, 1) and inReady (output, 1) as the request handshake.
REQ-009 The module SHALL have ports outValid (output, 1) and outReady (input, 1) as the result handshake.
REQ-010 The module SHALL have port sum, output, NUM_SIZE, result modulo 2^NUM_SIZE.
REQ-011 The module SHALL have ports overflow, carryOut and zero, outputs, 1 each: signed overflow, carry out of MSB, sum == 0.

Function
REQ-012 The FSM SHALL have states IDLE, BUSY, DONE; CHUNKS = NUM_SIZE/CHUNK_SIZE.
REQ-013 In IDLE, inReady SHALL be 1; in BUSY and DONE, inReady SHALL be 0.
REQ-014 On an IDLE edge with inValid=1: latch dIn0, dIn1 (bitwise inverted if sub=1), set carry register to sub, set chunk index 0, go to BUSY.
REQ-015 Operands SHALL be sampled only at acceptance; later input changes SHALL NOT affect the result.
REQ-016 Each BUSY edge SHALL add chunk[index] of both latched operands plus carry, write the chunk into sum, update carry, and increment index.
REQ-017 On the edge that processes chunk CHUNKS-1: carryOut = carry out of MSB, overflow = carry into MSB XOR carry out of MSB, zero = (final sum == 0), go to DONE.
REQ-018 Latency: acceptance at edge 0 SHALL yield outValid=1 from the cycle after edge CHUNKS (CHUNKS+1 cycles after acceptance cycle starts).
REQ-019 In DONE, outValid SHALL be 1 and sum/flags SHALL hold stable until an edge with outReady=1, which returns the FSM to IDLE.
REQ-020 outValid SHALL be 0 outside DONE; sum/flags in IDLE SHALL keep the last result.
REQ-021 For sub=1, carryOut=1 SHALL mean no borrow (dIn0 >= dIn1 unsigned).
REQ-022 inValid during BUSY/DONE SHALL be ignored (no acceptance, no state change).
REQ-023 CHUNK_SIZE == NUM_SIZE SHALL be legal (single BUSY cycle).

Reset
REQ-024 On an edge with rst=1, from any state including mid-BUSY: state IDLE, index 0, carry 0, sum 0, overflow 0, carryOut 0, zero 0, outValid 0; an in-flight operation SHALL be discarded.
REQ-025 rst SHALL take priority over every handshake on the same edge.

Structure
REQ-026 State encodings and the CHUNKS derivation SHALL reside in a shared include header reused by later arithmetic units.
REQ-027 One combinational sub-module chunk_adder (CHUNK_SIZE-bit a, b, cIn -> sum, cOut, cMsb) SHALL be instantiated once; all sequencing lives in chunk_addsub.

Verification (NUM_SIZE=32, CHUNK_SIZE=8 unless stated)
REQ-028 0x7FFFFFFF + 0x00000001, sub=0 -> sum 0x80000000, overflow 1, carryOut 0, zero 0, outValid first high 5 cycles after acceptance.
REQ-029 5 - 7, sub=1 -> sum 0xFFFFFFFE, overflow 0, carryOut 0, zero 0.
REQ-030 0xFFFFFFFF + 0x00000001 -> sum 0, carryOut 1, overflow 0, zero 1.
REQ-031 outReady held 0 for 3 cycles in DONE with inValid=1 and changing dIn0 -> sum/flags stable, inReady 0, no new acceptance until the outReady edge.
REQ-032 rst asserted on the third BUSY edge -> next cycle IDLE, inReady 1, outValid 0, sum 0, all flags 0; a following 1 + 1 -> sum 2.
REQ-033 NUM_SIZE=8, CHUNK_SIZE=8: 0x80 - 0x01, sub=1 -> sum 0x7F, overflow 1, carryOut 1, outValid 2 cycles after acceptance.

Source files
------------

// File: rtl/chunk_addsub_pkg.sv
// Shared definitions for the chunk-serial arithmetic units: FSM state
// encodings and helpers that derive chunk count and index width.
package chunk_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } addsub_state_e;

  function automatic int chunk_count(input int num_size, input int chunk_size);
    return num_size / chunk_size;
  endfunction

  // A single-chunk unit still needs a 1-bit index register.
  function automatic int idx_width(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

// File: rtl/chunk_addsub_adder.sv
// Combinational CHUNK_SIZE-bit adder slice; cMsb is the carry into the top bit,
// used by the sequencer to form signed overflow on the last chunk.
module chunk_adder #(
  parameter int CHUNK_SIZE = 8
) (
  input  logic [CHUNK_SIZE-1:0] a,
  input  logic [CHUNK_SIZE-1:0] b,
  input  logic                  cIn,
  output logic [CHUNK_SIZE-1:0] sum,
  output logic                  cOut,
  output logic                  cMsb
);

  logic [CHUNK_SIZE:0] full;

  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{CHUNK_SIZE{1'b0}}, cIn};
    sum  = full[CHUNK_SIZE-1:0];
    cOut = full[CHUNK_SIZE];
    cMsb = a[CHUNK_SIZE-1] ^ b[CHUNK_SIZE-1] ^ full[CHUNK_SIZE-1];
  end

endmodule

// File: rtl/chunk_addsub.sv
// Chunk-serial adder/subtractor: one CHUNK_SIZE slice per BUSY cycle, LSB first,
// with valid/ready handshakes on both request and result sides.
module chunk_addsub
  import chunk_addsub_pkg::*;
#(
  parameter int NUM_SIZE   = 32,
  parameter int CHUNK_SIZE = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SIZE-1:0] dIn0,
  input  logic [NUM_SIZE-1:0] dIn1,
  input  logic                sub,
  input  logic                inValid,
  output logic                inReady,
  output logic                outValid,
  input  logic                outReady,
  output logic [NUM_SIZE-1:0] sum,
  output logic                overflow,
  output logic                carryOut,
  output logic                zero
);

  localparam int CHUNKS = chunk_count(NUM_SIZE, CHUNK_SIZE);
  localparam int IDX_W  = idx_width(CHUNKS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  addsub_state_e       state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [NUM_SIZE-1:0] a_q, a_d;
  logic [NUM_SIZE-1:0] b_q, b_d;
  logic [NUM_SIZE-1:0] sum_q, sum_d;
  logic                ovf_q, ovf_d;
  logic                cout_q, cout_d;
  logic                zero_q, zero_d;

  logic [CHUNK_SIZE-1:0] ch_a, ch_b, ch_sum;
  logic                  ch_cout, ch_cmsb;

  assign ch_a = a_q[idx_q*CHUNK_SIZE +: CHUNK_SIZE];
  assign ch_b = b_q[idx_q*CHUNK_SIZE +: CHUNK_SIZE];

  chunk_adder #(.CHUNK_SIZE(CHUNK_SIZE)) u_chunk_adder (
    .a   (ch_a),
    .b   (ch_b),
    .cIn (carry_q),
    .sum (ch_sum),
    .cOut(ch_cout),
    .cMsb(ch_cmsb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (inValid) begin
          // Subtraction as a + ~b + 1: the +1 rides in on the initial carry.
          a_d     = dIn0;
          b_d     = sub ? ~dIn1 : dIn1;
          carry_d = sub;
          idx_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        sum_d[idx_q*CHUNK_SIZE +: CHUNK_SIZE] = ch_sum;
        carry_d = ch_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = ch_cout;
          ovf_d   = ch_cmsb ^ ch_cout;
          zero_d  = (sum_d == '0);
          idx_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (outReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  assign inReady  = (state_q == ST_IDLE);
  assign outValid = (state_q == ST_DONE);
  assign sum      = sum_q;
  assign overflow = ovf_q;
  assign carryOut = cout_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_chunk_addsub.sv
// Directed bench for chunk_addsub: a 32/8 instance for the main scenarios and
// an 8/8 instance for the single-chunk case.
module tb_chunk_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] dIn0, dIn1, sum;
  logic        sub, inValid, inReady, outValid, outReady;
  logic        overflow, carryOut, zero;

  logic [7:0]  s_dIn0, s_dIn1, s_sum;
  logic        s_sub, s_inValid, s_inReady, s_outValid, s_outReady;
  logic        s_overflow, s_carryOut, s_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chunk_addsub #(.NUM_SIZE(32), .CHUNK_SIZE(8)) dut (
    .clk(clk), .rst(rst), .dIn0(dIn0), .dIn1(dIn1), .sub(sub),
    .inValid(inValid), .inReady(inReady), .outValid(outValid), .outReady(outReady),
    .sum(sum), .overflow(overflow), .carryOut(carryOut), .zero(zero)
  );

  chunk_addsub #(.NUM_SIZE(8), .CHUNK_SIZE(8)) dut_s (
    .clk(clk), .rst(rst), .dIn0(s_dIn0), .dIn1(s_dIn1), .sub(s_sub),
    .inValid(s_inValid), .inReady(s_inReady), .outValid(s_outValid), .outReady(s_outReady),
    .sum(s_sum), .overflow(s_overflow), .carryOut(s_carryOut), .zero(s_zero)
  );

  // Launches one operation, scrambles the inputs right after acceptance, and
  // returns the number of edges until outValid (99 if it never rises).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat);
    @(negedge clk);
    dIn0 = a; dIn1 = b; sub = s; inValid = 1'b1;
    @(posedge clk); #1;
    inValid = 1'b0; dIn0 = ~a; dIn1 = 32'h1234_5678; sub = ~s;
    lat = 0;
    while (!outValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!outValid) lat = 99;
  endtask

  task automatic release_result();
    @(negedge clk); outReady = 1'b1;
    @(posedge clk); #1; outReady = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got %b exp 1", inReady); end
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got %b exp 0", outValid); end
    checks++; if ({sum, overflow, carryOut, zero} !== 35'd0) begin errors++;
      $display("FAIL reset_result got %h %b%b%b exp 0", sum, overflow, carryOut, zero); end
    checks++; if ({s_inReady, s_outValid, s_sum, s_overflow, s_carryOut, s_zero} !== {1'b1, 12'd0}) begin
      errors++; $display("FAIL reset_small got rdy %b vld %b sum %h", s_inReady, s_outValid, s_sum); end
  endtask

  task automatic test_signed_overflow();
    int lat;
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL ovf_latency got %0d exp 4", lat); end
    checks++; if (sum !== 32'h8000_0000) begin errors++; $display("FAIL ovf_sum got %h exp 80000000", sum); end
    checks++; if ({overflow, carryOut, zero} !== 3'b100) begin errors++;
      $display("FAIL ovf_flags got %b exp 100", {overflow, carryOut, zero}); end
    checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL ovf_inReady_done got %b exp 0", inReady); end
    release_result();
    checks++; if ({inReady, outValid} !== 2'b10) begin errors++;
      $display("FAIL ovf_release got rdy/vld %b exp 10", {inReady, outValid}); end
    checks++; if ({sum, overflow} !== {32'h8000_0000, 1'b1}) begin errors++;
      $display("FAIL ovf_idle_hold got %h %b exp 80000000 1", sum, overflow); end
  endtask

  task automatic test_sub_borrow();
    int lat;
    run_op(32'd5, 32'd7, 1'b1, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL borrow_latency got %0d exp 4", lat); end
    checks++; if (sum !== 32'hFFFF_FFFE) begin errors++; $display("FAIL borrow_sum got %h exp fffffffe", sum); end
    checks++; if ({overflow, carryOut, zero} !== 3'b000) begin errors++;
      $display("FAIL borrow_flags got %b exp 000", {overflow, carryOut, zero}); end
    release_result();
  endtask

  task automatic test_wrap_zero();
    int lat;
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    checks++; if (sum !== 32'h0) begin errors++; $display("FAIL wrap_sum got %h exp 00000000", sum); end
    checks++; if ({overflow, carryOut, zero} !== 3'b011) begin errors++;
      $display("FAIL wrap_flags got %b exp 011", {overflow, carryOut, zero}); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(32'd10, 32'd3, 1'b1, lat);
    checks++; if ({sum, overflow, carryOut, zero} !== {32'd7, 3'b010}) begin errors++;
      $display("FAIL b2b_first got %h %b exp 00000007 010", sum, {overflow, carryOut, zero}); end
    release_result();
    run_op(32'h8000_0000, 32'd1, 1'b1, lat);
    checks++; if ({sum, overflow, carryOut, zero} !== {32'h7FFF_FFFF, 3'b110}) begin errors++;
      $display("FAIL b2b_second got %h %b exp 7fffffff 110", sum, {overflow, carryOut, zero}); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b2b_latency got %0d exp 4", lat); end
  endtask

  // Enters with a result already pending in DONE from the previous task.
  task automatic test_hold_done();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); inValid = 1'b1; dIn0 = 32'h1111_0000 + i; dIn1 = 32'd1; sub = 1'b0;
      @(posedge clk); #1;
      checks++; if ({outValid, inReady, sum, overflow, carryOut, zero} !== {2'b10, 32'h7FFF_FFFF, 3'b110}) begin
        errors++; $display("FAIL hold_cycle%0d got vld %b rdy %b sum %h flags %b", i, outValid, inReady,
                           sum, {overflow, carryOut, zero}); end
    end
    @(negedge clk); inValid = 1'b0; outReady = 1'b1;
    @(posedge clk); #1; outReady = 1'b0;
    checks++; if ({inReady, outValid} !== 2'b10) begin errors++;
      $display("FAIL hold_release got rdy/vld %b exp 10", {inReady, outValid}); end
    @(posedge clk); #1;
    checks++; if ({inReady, sum} !== {1'b1, 32'h7FFF_FFFF}) begin errors++;
      $display("FAIL hold_no_accept got rdy %b sum %h exp 1 7fffffff", inReady, sum); end
  endtask

  task automatic test_reset_mid_busy();
    int lat;
    @(negedge clk); dIn0 = 32'hFFFF_FFFF; dIn1 = 32'd1; sub = 1'b0; inValid = 1'b1;
    @(posedge clk); #1; inValid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++; if ({inReady, outValid} !== 2'b10) begin errors++;
      $display("FAIL midrst_hs got rdy/vld %b exp 10", {inReady, outValid}); end
    checks++; if ({sum, overflow, carryOut, zero} !== 35'd0) begin errors++;
      $display("FAIL midrst_result got %h %b exp 0", sum, {overflow, carryOut, zero}); end
    run_op(32'd1, 32'd1, 1'b0, lat);
    checks++; if ({sum, overflow, carryOut, zero} !== {32'd2, 3'b000}) begin errors++;
      $display("FAIL midrst_after got %h %b exp 00000002 000", sum, {overflow, carryOut, zero}); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency got %0d exp 4", lat); end
    release_result();
  endtask

  task automatic test_single_chunk();
    int lat;
    @(negedge clk); s_dIn0 = 8'h80; s_dIn1 = 8'h01; s_sub = 1'b1; s_inValid = 1'b1;
    @(posedge clk); #1; s_inValid = 1'b0; s_dIn0 = 8'h00;
    lat = 0;
    while (!s_outValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 1) begin errors++; $display("FAIL single_latency got %0d exp 1", lat); end
    checks++; if ({s_sum, s_overflow, s_carryOut, s_zero} !== {8'h7F, 3'b110}) begin errors++;
      $display("FAIL single_result got %h %b exp 7f 110", s_sum, {s_overflow, s_carryOut, s_zero}); end
    @(negedge clk); s_outReady = 1'b1;
    @(posedge clk); #1; s_outReady = 1'b0;
    checks++; if ({s_inReady, s_outValid} !== 2'b10) begin errors++;
      $display("FAIL single_release got rdy/vld %b exp 10", {s_inReady, s_outValid}); end
  endtask

  initial begin
    rst = 1'b1; dIn0 = '0; dIn1 = '0; sub = 1'b0; inValid = 1'b0; outReady = 1'b0;
    s_dIn0 = '0; s_dIn1 = '0; s_sub = 1'b0; s_inValid = 1'b0; s_outReady = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_signed_overflow();
    test_sub_borrow();
    test_wrap_zero();
    test_back_to_back();
    test_hold_done();
    test_reset_mid_busy();
    test_single_chunk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
